uart_mmio_ctrl: RTL and testbench

Memory-mapped I/O controller between the CPU's load/store path and the on-chip UART receiver/transmitter pair. It decodes MMIO addresses and buffers received bytes in a small RX FIFO. It sequences transmit bytes through a one-entry holding register with a ready/valid handshake, and it keeps the cycle and retired-instruction counters that software reads for benchmarking. It sits beside the data memory in the CPU's memory stage; its read data is muxed into the load writeback path.

---
 rtl/uart_mmio_ctrl.sv | 150 +++++++++++++++
 tb/tb_uart_mmio_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_mmio_ctrl.sv
// MMIO controller bridging the CPU load/store path to a UART RX/TX pair.
// Holds the RX FIFO, the one-entry TX holding register and the benchmark counters.
module uart_mmio_ctrl #(
    parameter int          RX_FIFO_DEPTH = 4,
    parameter logic [31:0] MMIO_BASE     = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        inst_retired,
    output logic [31:0] rdata,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);

    localparam int          AW       = (RX_FIFO_DEPTH > 1) ? $clog2(RX_FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(RX_FIFO_DEPTH);

    localparam logic [31:0] OFF_CTRL    = 32'h00;
    localparam logic [31:0] OFF_RX      = 32'h04;
    localparam logic [31:0] OFF_TX      = 32'h08;
    localparam logic [31:0] OFF_CYCLE   = 32'h10;
    localparam logic [31:0] OFF_INST    = 32'h14;
    localparam logic [31:0] OFF_CNT_RST = 32'h18;

    logic [31:0]   offset;
    logic          sel_ctrl;
    logic          sel_rx;
    logic          sel_tx;
    logic          sel_cycle;
    logic          sel_inst;
    logic          sel_cnt_rst;

    logic [7:0]    rx_mem [RX_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   rx_count;
    logic          rx_full;
    logic          rx_empty;
    logic          rx_push;
    logic          rx_pop;

    logic          tx_fire;
    logic          tx_store;
    logic          cnt_clear;

    logic [31:0]   cycle_cnt;
    logic [31:0]   inst_cnt;
    logic [31:0]   read_val;

    logic          unused_bits;
    assign unused_bits = ^wdata[31:8];

    assign offset      = addr - MMIO_BASE;
    assign sel_ctrl    = (offset == OFF_CTRL);
    assign sel_rx      = (offset == OFF_RX);
    assign sel_tx      = (offset == OFF_TX);
    assign sel_cycle   = (offset == OFF_CYCLE);
    assign sel_inst    = (offset == OFF_INST);
    assign sel_cnt_rst = (offset == OFF_CNT_RST);

    assign rx_full       = (rx_count == FULL_CNT);
    assign rx_empty      = (rx_count == '0);
    assign uart_rx_ready = !rx_full && !rst;
    assign rx_push       = uart_rx_valid && uart_rx_ready;
    // An empty FIFO never pops, even if a push lands on the same edge.
    assign rx_pop        = re && sel_rx && !rx_empty;

    // Holding register is full whenever a handshake can occur, so the two never overlap.
    assign tx_fire   = uart_tx_valid && uart_tx_ready;
    assign tx_store  = we && sel_tx && !uart_tx_valid;
    assign cnt_clear = we && sel_cnt_rst;

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[wr_ptr] <= uart_rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rx_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + 1'b1;
                2'b01:   rx_count <= rx_count - 1'b1;
                default: rx_count <= rx_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= 8'h00;
        end else if (tx_fire) begin
            uart_tx_valid <= 1'b0;
        end else if (tx_store) begin
            uart_tx_valid <= 1'b1;
            uart_tx_data  <= wdata[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            inst_cnt  <= inst_cnt + {31'd0, inst_retired};
        end
    end

    always_comb begin
        read_val = '0;
        if (sel_ctrl) begin
            read_val = {29'd0, 1'b0, !rx_empty, !uart_tx_valid};
        end else if (sel_rx) begin
            read_val = rx_empty ? 32'd0 : {24'd0, rx_mem[rd_ptr]};
        end else if (sel_cycle) begin
            read_val = cycle_cnt;
        end else if (sel_inst) begin
            read_val = inst_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= read_val;
        end
    end

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Directed bench for uart_mmio_ctrl; load results are checked through an expected-value queue.
module tb_uart_mmio_ctrl;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        inst_retired;
    logic [31:0] rdata;
    logic [7:0]  uart_rx_data;
    logic        uart_rx_valid;
    logic        uart_rx_ready;
    logic [7:0]  uart_tx_data;
    logic        uart_tx_valid;
    logic        uart_tx_ready;

    int n_pass  = 0;
    int n_total = 0;
    logic [31:0] exp_q [$];

    uart_mmio_ctrl #(.RX_FIFO_DEPTH(4), .MMIO_BASE(BASE)) dut (
        .clk           (clk),
        .rst           (rst),
        .addr          (addr),
        .wdata         (wdata),
        .we            (we),
        .re            (re),
        .inst_retired  (inst_retired),
        .rdata         (rdata),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_ready (uart_rx_ready),
        .uart_tx_data  (uart_tx_data),
        .uart_tx_valid (uart_tx_valid),
        .uart_tx_ready (uart_tx_ready)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    // Drives a one-cycle load; the expected value is queued with the stimulus
    // and compared when the registered rdata appears after the edge.
    task automatic mmio_read(input logic [31:0] off, input logic [31:0] exp, input string tag);
        logic [31:0] e;
        addr = BASE + off;
        re   = 1'b1;
        exp_q.push_back(exp);
        step();
        re = 1'b0;
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check(tag, rdata, e);
        end
    endtask

    task automatic mmio_write(input logic [31:0] off, input logic [31:0] data);
        addr  = BASE + off;
        wdata = data;
        we    = 1'b1;
        step();
        we = 1'b0;
    endtask

    task automatic rx_send(input logic [7:0] data);
        uart_rx_data  = data;
        uart_rx_valid = 1'b1;
        step();
        uart_rx_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; addr = BASE; wdata = '0; we = 1'b0; re = 1'b0; inst_retired = 1'b0;
        uart_rx_data = '0; uart_rx_valid = 1'b0; uart_tx_ready = 1'b0;
        step(); step(); step();
        check("rx_ready_in_reset", {31'd0, uart_rx_ready}, 32'd0);
        rst = 1'b0;
        #1;
        check("rx_ready_after_reset", {31'd0, uart_rx_ready}, 32'd1);
        check("tx_valid_reset", {31'd0, uart_tx_valid}, 32'd0);
        check("tx_data_reset", {24'd0, uart_tx_data}, 32'd0);
        check("rdata_reset", rdata, 32'd0);
        mmio_read(32'h00, 32'h1, "ctrl_idle");

        // Fill the FIFO; the fifth byte is held off while full.
        rx_send(8'h61);
        rx_send(8'h62);
        rx_send(8'h63);
        check("rx_ready_count3", {31'd0, uart_rx_ready}, 32'd1);
        rx_send(8'h64);
        check("rx_ready_full", {31'd0, uart_rx_ready}, 32'd0);
        uart_rx_data  = 8'h65;
        uart_rx_valid = 1'b1;
        step();
        check("rx_ready_held_off", {31'd0, uart_rx_ready}, 32'd0);
        mmio_read(32'h04, 32'h61, "rx_pop1");
        check("rx_ready_after_pop", {31'd0, uart_rx_ready}, 32'd1);
        mmio_read(32'h04, 32'h62, "rx_pop2");
        uart_rx_valid = 1'b0;
        mmio_read(32'h04, 32'h63, "rx_pop3");
        mmio_read(32'h04, 32'h64, "rx_pop4");
        mmio_read(32'h04, 32'h65, "rx_pop5");
        mmio_read(32'h04, 32'h00, "rx_pop_empty");
        mmio_read(32'h00, 32'h1, "ctrl_drained");
        mmio_read(32'h0C, 32'h0, "unmapped_read");
        mmio_write(32'h00, 32'hFFFF_FFFF);
        mmio_read(32'h00, 32'h1, "ctrl_write_ignored");

        // TX holding register: second store while full is dropped.
        mmio_write(32'h08, 32'h41);
        check("tx_valid_set", {31'd0, uart_tx_valid}, 32'd1);
        check("tx_data_41", {24'd0, uart_tx_data}, 32'h41);
        mmio_read(32'h00, 32'h0, "ctrl_tx_full");
        mmio_write(32'h08, 32'h42);
        check("tx_data_kept", {24'd0, uart_tx_data}, 32'h41);
        check("tx_valid_kept", {31'd0, uart_tx_valid}, 32'd1);
        step();
        check("rdata_holds", rdata, 32'h0);
        uart_tx_ready = 1'b1;
        step();
        uart_tx_ready = 1'b0;
        check("tx_valid_cleared", {31'd0, uart_tx_valid}, 32'd0);
        mmio_read(32'h00, 32'h1, "ctrl_tx_free");

        // A store on the handshake edge is dropped.
        mmio_write(32'h08, 32'h43);
        uart_tx_ready = 1'b1;
        mmio_write(32'h08, 32'h44);
        uart_tx_ready = 1'b0;
        check("tx_same_edge_valid", {31'd0, uart_tx_valid}, 32'd0);
        check("tx_same_edge_data", {24'd0, uart_tx_data}, 32'h43);

        // Push and pop on the same edge.
        rx_send(8'h50);
        uart_rx_data  = 8'h70;
        uart_rx_valid = 1'b1;
        mmio_read(32'h04, 32'h50, "rx_pushpop_old");
        uart_rx_valid = 1'b0;
        mmio_read(32'h04, 32'h70, "rx_pushpop_new");
        mmio_read(32'h00, 32'h1, "ctrl_pushpop_empty");
        uart_rx_data  = 8'h71;
        uart_rx_valid = 1'b1;
        mmio_read(32'h04, 32'h00, "rx_empty_push");
        uart_rx_valid = 1'b0;
        mmio_read(32'h04, 32'h71, "rx_empty_push_landed");

        // Counters over a known window.
        mmio_write(32'h18, 32'h0);
        for (int i = 0; i < 100; i++) begin
            inst_retired = (i % 2 == 0);
            step();
        end
        inst_retired = 1'b0;
        mmio_read(32'h10, 32'd100, "cycle_cnt_100");
        mmio_read(32'h14, 32'd50, "inst_cnt_50");
        mmio_write(32'h18, 32'h1);
        mmio_read(32'h10, 32'd0, "cycle_cnt_cleared");
        mmio_read(32'h14, 32'd0, "inst_cnt_cleared");

        // Reset with traffic in flight.
        rx_send(8'h81);
        rx_send(8'h82);
        rx_send(8'h83);
        mmio_write(32'h08, 32'h90);
        check("tx_valid_pre_rst", {31'd0, uart_tx_valid}, 32'd1);
        mmio_read(32'h00, 32'h2, "ctrl_pre_rst");
        inst_retired = 1'b1;
        rst = 1'b1;
        step();
        check("tx_valid_rst", {31'd0, uart_tx_valid}, 32'd0);
        check("rx_ready_rst", {31'd0, uart_rx_ready}, 32'd0);
        check("rdata_rst", rdata, 32'd0);
        rst = 1'b0;
        inst_retired = 1'b0;
        mmio_read(32'h10, 32'd0, "cycle_cnt_post_rst");
        mmio_read(32'h14, 32'd0, "inst_cnt_post_rst");
        mmio_read(32'h00, 32'h1, "ctrl_post_rst");
        mmio_read(32'h04, 32'h0, "rx_post_rst");

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
